// File: rtl/console_uart_tx.sv
// console_uart_tx: memory-mapped 8N1 console transmitter on the data-RAM port.
// Bytes written to TXDATA are queued in a FIFO and shifted out LSB first.
// Ports:
//   clk, rst                clock (rising edge), asynchronous active-low reset
//   ram_cen, ram_wen        bus strobe, 1 = write / 0 = read
//   ram_flag, ram_addr      byte enables, byte address
//   ram_wdata, ram_rdata    write data, registered read data (1-cycle latency)
//   uart_txd                serial line, idle high
//   uart_irq                level interrupt: irq_en & fifo empty & shifter idle
module console_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'hE000_0000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_cen,
  input  logic        ram_wen,
  input  logic [3:0]  ram_flag,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_wdata,
  output logic [31:0] ram_rdata,
  output logic        uart_txd,
  output logic        uart_irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 16;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus decode
  logic       hit, rd_en, wr_en;
  logic [1:0] sel;
  assign hit   = ram_cen & (ram_addr[31:4] == BASE_ADDR[31:4]);
  assign sel   = ram_addr[3:2];
  assign rd_en = hit & ~ram_wen;
  assign wr_en = hit & ram_wen;

  logic unused_bits;
  assign unused_bits = ^{ram_addr[1:0], ram_flag[3:2], ram_wdata[31:16]};

  // FIFO storage and occupancy
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty, push_req, push, pop, ovf_set;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push_req   = wr_en & (sel == REG_TXDATA) & ram_flag[0];
  // A push while full still lands if the shifter frees a slot on the same edge
  assign push       = push_req & (~fifo_full | pop);
  assign ovf_set    = push_req & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Shifter state
  state_t        state, state_d;
  logic [DW-1:0] timer, timer_d, div_lat, div_lat_d, divisor, div_eff;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          txd_d, busy, irq_en, overflow;

  assign busy    = (state != S_IDLE);
  assign div_eff = (divisor == '0) ? DW'(1) : divisor;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      uart_txd <= 1'b1;
      timer    <= '0;
      idx      <= '0;
      shreg    <= '0;
      div_lat  <= DIV_RESET;
    end else begin
      state    <= state_d;
      uart_txd <= txd_d;
      timer    <= timer_d;
      idx      <= idx_d;
      shreg    <= shreg_d;
      div_lat  <= div_lat_d;
    end
  end

  // Next-state: each bit is held div_lat cycles, timer counts div_lat-1 down to 0
  always_comb begin
    state_d   = state;
    txd_d     = 1'b1;
    timer_d   = timer;
    idx_d     = idx;
    shreg_d   = shreg;
    div_lat_d = div_lat;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_d   = fifo_mem[rd_ptr];
          div_lat_d = div_eff;
          timer_d   = div_eff - DW'(1);
          state_d   = S_START;
          txd_d     = 1'b0;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (timer == '0) begin
          state_d = S_DATA;
          idx_d   = '0;
          timer_d = div_lat - DW'(1);
          txd_d   = shreg[0];
        end else begin
          timer_d = timer - DW'(1);
        end
      end
      S_DATA: begin
        txd_d = shreg[idx];
        if (timer == '0) begin
          timer_d = div_lat - DW'(1);
          if (idx == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            idx_d = idx + 3'd1;
            txd_d = shreg[idx + 3'd1];
          end
        end else begin
          timer_d = timer - DW'(1);
        end
      end
      S_STOP: begin
        if (timer == '0) state_d = S_IDLE;
        else             timer_d = timer - DW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read mux
  logic [31:0] rd_val;
  always_comb begin
    rd_val = '0;
    case (sel)
      REG_STATUS: rd_val = {28'd0, overflow, busy, fifo_empty, fifo_full};
      REG_DIV:    rd_val = {16'd0, divisor};
      REG_CTRL:   rd_val = {31'd0, irq_en};
      default:    rd_val = '0;
    endcase
  end

  // Control registers, sticky overflow, read data and interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor   <= DIV_RESET;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
      ram_rdata <= '0;
      uart_irq  <= 1'b0;
    end else begin
      if (wr_en && (sel == REG_DIV)) begin
        if (ram_flag[0]) divisor[7:0]  <= ram_wdata[7:0];
        if (ram_flag[1]) divisor[15:8] <= ram_wdata[15:8];
      end
      if (wr_en && (sel == REG_CTRL) && ram_flag[0]) irq_en <= ram_wdata[0];
      // A new overflow beats the read-to-clear on the same edge
      if (ovf_set)                              overflow <= 1'b1;
      else if (rd_en && (sel == REG_STATUS))    overflow <= 1'b0;
      if (rd_en) ram_rdata <= rd_val;
      uart_irq <= irq_en & fifo_empty & ~busy;
    end
  end

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed self-checking bench for console_uart_tx.
module tb_console_uart_tx;

  localparam logic [31:0] A_STATUS = 32'hE000_0000;
  localparam logic [31:0] A_TXDATA = 32'hE000_0004;
  localparam logic [31:0] A_DIV    = 32'hE000_0008;
  localparam logic [31:0] A_CTRL   = 32'hE000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_cen = 1'b0;
  logic        ram_wen = 1'b0;
  logic [3:0]  ram_flag = 4'h0;
  logic [31:0] ram_addr = 32'h0;
  logic [31:0] ram_wdata = 32'h0;
  logic [31:0] ram_rdata;
  logic        uart_txd;
  logic        uart_irq;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic prev_txd = 1'b1;
  logic prev_irq = 1'b0;
  int falls[$];
  int rises[$];

  console_uart_tx #(
    .BASE_ADDR (32'hE000_0000),
    .FIFO_DEPTH(16),
    .DIV_RESET (16'd8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ram_cen  (ram_cen),
    .ram_wen  (ram_wen),
    .ram_flag (ram_flag),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .uart_txd (uart_txd),
    .uart_irq (uart_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_txd && !uart_txd) falls.push_back(cyc);
    if (!prev_irq && uart_irq) rises.push_back(cyc);
    prev_txd = uart_txd;
    prev_irq = uart_irq;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] flag);
    ram_cen = 1'b1; ram_wen = 1'b1; ram_addr = addr; ram_wdata = data; ram_flag = flag;
    step();
    ram_cen = 1'b0; ram_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    ram_cen = 1'b1; ram_wen = 1'b0; ram_addr = addr; ram_flag = 4'hF;
    step();
    data = ram_rdata;
    ram_cen = 1'b0;
  endtask

  // Check frame sample indices k_from..k_to-1; index 0 is the first low sample
  task automatic expect_frame(input logic [7:0] b, input int div, input int k_from, input int k_to,
                              input bit chk_busy, input string tag);
    logic [9:0] bits;
    logic exp_bit;
    bits = {1'b1, b, 1'b0};
    if (chk_busy) begin
      ram_cen = 1'b1; ram_wen = 1'b0; ram_addr = A_STATUS;
    end
    for (int k = k_from; k < k_to; k++) begin
      step();
      exp_bit = bits[4'(k / div)];
      check($sformatf("%s txd k=%0d", tag, k), 32'(uart_txd), 32'(exp_bit));
      if (chk_busy && k > 0)
        check($sformatf("%s busy k=%0d", tag, k), 32'(ram_rdata[2]), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int lows;

    // Reset state
    rst = 1'b1;
    #3 rst = 1'b0;
    step(); step();
    check("rst txd", 32'(uart_txd), 32'd1);
    check("rst irq", 32'(uart_irq), 32'd0);
    check("rst rdata", ram_rdata, 32'h0);
    rst = 1'b1;
    step();
    bus_read(A_STATUS, rd);
    check("status after reset", rd, 32'h2);
    bus_read(A_DIV, rd);
    check("divisor reset", rd, 32'h8);

    // Ignored writes: off-page address and TXDATA without byte 0 enabled
    bus_write(32'hE000_0014, 32'h42, 4'hF);
    bus_write(A_TXDATA, 32'h43, 4'b1110);
    step(); step();
    check("no push txd", 32'(uart_txd), 32'd1);
    bus_read(A_STATUS, rd);
    check("no push status", rd, 32'h2);
    bus_read(A_TXDATA, rd);
    check("txdata reads 0", rd, 32'h0);
    bus_write(A_CTRL, 32'h1, 4'hF);
    bus_read(A_CTRL, rd);
    check("ctrl readback", rd, 32'h1);
    step(); step();
    check("rdata holds", ram_rdata, 32'h1);
    bus_write(A_CTRL, 32'h0, 4'hF);
    step();

    // Single frame 0x55 at DIV=4 with busy tracking
    bus_write(A_DIV, 32'h4, 4'b0011);
    bus_read(A_DIV, rd);
    check("div=4 readback", rd, 32'h4);
    bus_write(A_TXDATA, 32'h55, 4'b0001);
    expect_frame(8'h55, 4, 0, 40, 1'b1, "f55");
    step(); step();
    check("f55 idle status", ram_rdata, 32'h2);
    check("f55 idle txd", 32'(uart_txd), 32'd1);
    ram_cen = 1'b0;

    // Fill to full at DIV=2, then overflow
    bus_write(A_DIV, 32'h2, 4'b0011);
    for (int i = 0; i < 17; i++) bus_write(A_TXDATA, 32'(i), 4'b0001);
    bus_write(A_TXDATA, 32'h11, 4'b0001);
    bus_read(A_STATUS, rd);
    check("overflow status", rd, 32'hD);
    bus_read(A_STATUS, rd);
    check("overflow cleared", rd, 32'h5);
    expect_frame(8'h00, 2, 19, 20, 1'b0, "fill00");
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("gap before %0d", i), 32'(uart_txd), 32'd1);
      expect_frame(8'(i), 2, 0, 20, 1'b0, $sformatf("fill%02h", i));
    end
    step(); step();
    bus_read(A_STATUS, rd);
    check("drained status", rd, 32'h2);

    // Back-to-back frames at DIV=1 and the TX-empty interrupt
    bus_write(A_DIV, 32'h1, 4'b0011);
    falls.delete();
    rises.delete();
    bus_write(A_TXDATA, 32'hFF, 4'b0001);
    bus_write(A_CTRL, 32'h1, 4'b0001);
    bus_write(A_TXDATA, 32'h80, 4'b0001);
    bus_write(A_TXDATA, 32'hFF, 4'b0001);
    for (int i = 0; i < 40; i++) step();
    check("frame count", 32'(falls.size()), 32'd3);
    check("irq rise count", 32'(rises.size()), 32'd1);
    if (falls.size() == 3) begin
      check("spacing 0-1", 32'(falls[1] - falls[0]), 32'd11);
      check("spacing 1-2", 32'(falls[2] - falls[1]), 32'd11);
      if (rises.size() >= 1)
        check("irq delay", 32'(rises[0] - falls[2]), 32'd11);
    end
    check("irq level", 32'(uart_irq), 32'd1);
    bus_write(A_CTRL, 32'h0, 4'b0001);
    step();
    check("irq off", 32'(uart_irq), 32'd0);

    // Divisor change mid-frame applies to the next frame
    bus_write(A_DIV, 32'h8, 4'b0011);
    bus_write(A_TXDATA, 32'hA5, 4'b0001);
    bus_write(A_TXDATA, 32'h3C, 4'b0001);
    check("a5 start", 32'(uart_txd), 32'd0);
    expect_frame(8'hA5, 8, 1, 11, 1'b0, "a5");
    bus_write(A_DIV, 32'h2, 4'b0011);
    expect_frame(8'hA5, 8, 12, 80, 1'b0, "a5");
    step();
    check("a5 gap", 32'(uart_txd), 32'd1);
    expect_frame(8'h3C, 2, 0, 20, 1'b0, "3c");

    // Byte enables on DIVISOR and divisor 0 behaving as 1
    step(); step();
    bus_write(A_DIV, 32'hABCD_1234, 4'b0001);
    bus_read(A_DIV, rd);
    check("div byte0", rd, 32'h0034);
    bus_write(A_DIV, 32'hFFFF_5600, 4'b0010);
    bus_read(A_DIV, rd);
    check("div byte1", rd, 32'h5634);
    bus_write(A_DIV, 32'hFFFF_0000, 4'hF);
    bus_read(A_DIV, rd);
    check("div zero", rd, 32'h0);
    bus_write(A_TXDATA, 32'h81, 4'b0001);
    expect_frame(8'h81, 1, 0, 10, 1'b0, "div0");
    step(); step();
    bus_read(A_STATUS, rd);
    check("div0 idle", rd, 32'h2);

    // Reset during data bit 3 with four bytes queued
    bus_write(A_DIV, 32'h2, 4'b0011);
    for (int i = 0; i < 5; i++) bus_write(A_TXDATA, 32'h0, 4'b0001);
    for (int i = 0; i < 5; i++) step();
    check("bit3 low", 32'(uart_txd), 32'd0);
    rst = 1'b0;
    #1;
    check("abort txd", 32'(uart_txd), 32'd1);
    check("abort irq", 32'(uart_irq), 32'd0);
    check("abort rdata", ram_rdata, 32'h0);
    step(); step();
    rst = 1'b1;
    bus_read(A_STATUS, rd);
    check("post-reset status", rd, 32'h2);
    bus_read(A_DIV, rd);
    check("post-reset div", rd, 32'h8);
    bus_read(A_CTRL, rd);
    check("post-reset ctrl", rd, 32'h0);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!uart_txd) lows++;
    end
    check("no frames after reset", 32'(lows), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/console_uart_tx.md
Name: console_uart_tx

Overview:
- Memory-mapped console transmitter on the core's data-RAM port, decoded at the 0xE000_0000 I/O page.
- Replaces the simulation-only character print on writes to 0xE000_0004 with a real 8N1 serial line.
- Buffers bytes in a FIFO and provides polled status plus a TX-empty interrupt to the core's irq tree.

Parameters:
- BASE_ADDR, 32'hE000_0000, page base; decode compares ram_addr[31:4].
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- DIV_RESET, 16'd8, reset value of the DIVISOR register (clk cycles per bit).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- ram_cen  in  1  bus access strobe.
- ram_wen  in  1  1 = write, 0 = read.
- ram_flag  in  4  byte enables.
- ram_addr  in  32  byte address.
- ram_wdata  in  32  write data.
- ram_rdata  out  32  registered read data.
- uart_txd  out  1  serial output; idle high.
- uart_irq  out  1  level interrupt.

Behaviour:
- Hit = ram_cen & (ram_addr[31:4] == BASE_ADDR[31:4]); register select = ram_addr[3:2]; ram_addr[1:0] ignored.
- Register map:
  - 0x0 STATUS (R): bit0 fifo_full, bit1 fifo_empty, bit2 busy (shifter not IDLE), bit3 overflow (sticky); bits 31:4 = 0. A read clears overflow on the same edge that loads ram_rdata; a new overflow on that edge wins.
  - 0x4 TXDATA (W): pushes ram_wdata[7:0] only when ram_flag[0]=1; reads return 0.
  - 0x8 DIVISOR (RW): bits 15:0; byte enables honoured; reads bits 31:16 = 0; value 0 behaves as 1. Sampled only at frame start, so a mid-frame change affects the next frame.
  - 0xC CTRL (RW): bit0 irq_en; other bits read 0.
- Reads: on the edge with hit & ~ram_wen, ram_rdata <= selected register. One-cycle latency, matching the existing RAM read timing. ram_rdata holds its value otherwise and is not cleared by non-hit cycles.
- FIFO: count from 0 to FIFO_DEPTH.
  - Push when full: data dropped, overflow <= 1.
  - Push and pop on the same edge while full: both take effect, count unchanged, no overflow.
  - Push into an empty FIFO: the pop happens on the following edge, never the same edge.
  - Pointers wrap modulo FIFO_DEPTH.
- Shifter FSM, states IDLE, START, DATA, STOP:
  - IDLE: txd=1. If the FIFO is non-empty, pop the head into the shift register, latch the divisor into the bit counter, go to START.
  - START: txd=0 for DIV cycles.
  - DATA: 8 bits, LSB first, each held DIV cycles; a 3-bit index counts 0..7.
  - STOP: txd=1 for DIV cycles, then IDLE. IDLE lasts exactly one cycle when the FIFO is non-empty, so back-to-back frames are 10*DIV+1 cycles.
  - Bit timer counts DIV-1 down to 0; advance at 0.
- Latency: a write to an empty, idle block at edge N → pop at N+1 → uart_txd falls after edge N+1.
- uart_txd is registered from the FSM; no combinational path from bus to txd.
- uart_irq = irq_en & fifo_empty & ~busy, registered, one cycle after the condition.
- Reset values (rst=0, asynchronous):
  - Outputs: uart_txd=1, uart_irq=0, ram_rdata=0.
  - Internal: FIFO empty, overflow=0, DIVISOR=DIV_RESET, irq_en=0, FSM=IDLE.
- Reset mid-frame aborts the frame immediately (txd high); no partial-byte recovery.

Test Plan:
- Reset, then read STATUS → ram_rdata=32'h0000_0002 one cycle after the read edge; uart_txd=1; uart_irq=0.
- DIVISOR=4, write 0x55 to 0xE000_0004 → txd low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; busy=1 throughout, 0 after.
- DIVISOR=2; write 17 bytes 0x00..0x10 in consecutive cycles (first pops after 1 cycle) → 0x00 transmitted, 0x01..0x10 queued, no overflow. A write before the next pop sets STATUS=0x0000_000D (full, busy, overflow); the following STATUS read returns 0x...5.
- irq_en=1, send 3 bytes with DIV=1 → frames spaced 11 cycles; uart_irq rises exactly once, 1 cycle after the last stop bit ends.
- DIVISOR=8, start byte 0xA5, write DIVISOR=2 during DATA → current frame keeps 8-cycle bits; the next queued frame uses 2-cycle bits.
- Assert rst during bit 3 of a frame with 4 bytes queued → txd=1 immediately; after release, STATUS=0x2 and no further frames are sent.
